// File: rtl/ram_port_master.sv
// ram_port_master
// Sequences single read/write accesses onto one port of a 16x8 dual-port
// RAM. Commands are queued in a two-entry FIFO and executed one at a time,
// strictly in order. An access that is refused by the RAM arbiter (grant low)
// is re-driven unchanged. It is retried until MAX_RETRY non-granted cycles
// have elapsed, and is then returned as an error response.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata command payload
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_err            read data (0 for writes), abort flag
//   addr/read/write/write_data  RAM port drive, active only in ISSUE
//   read_data/grant             RAM registered read data, access executed
//   busy                        FSM not idle or FIFO not empty
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no command in flight; pops the FIFO head when available
// ISSUE     | driving the RAM access and waiting for grant
// WAIT_DATA | read granted; RAM read data valid this cycle
// RESP      | response held until rsp_ready

module ram_port_master #(
    parameter int MAX_RETRY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [3:0] addr,
    output logic       read,
    output logic       write,
    output logic [7:0] write_data,
    input  logic [7:0] read_data,
    input  logic       grant,
    output logic       busy
);

    // Wide enough to hold MAX_RETRY itself, so the count never wraps.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    // FIFO entry layout: {write, addr[3:0], wdata[7:0]}
    logic [1:0][12:0] fifo_q, fifo_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    state_t           state_q, state_d;
    logic             work_write_q, work_write_d;
    logic [3:0]       work_addr_q, work_addr_d;
    logic [7:0]       work_wdata_q, work_wdata_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             push;
    logic             pop;
    logic [12:0]      head;

    // Readiness looks only at the current fill level; a pop in the same
    // cycle does not free a slot early.
    assign cmd_ready = (count_q != 2'd2);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != 2'd0);
    assign head      = fifo_q[rd_ptr_q];

    // FIFO bookkeeping
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_wdata};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Next-state and work/response registers
    always_comb begin
        state_d      = state_q;
        work_write_d = work_write_q;
        work_addr_d  = work_addr_q;
        work_wdata_d = work_wdata_q;
        retry_d      = retry_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    work_write_d = head[12];
                    work_addr_d  = head[11:8];
                    work_wdata_d = head[7:0];
                    retry_d      = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (grant) begin
                    if (work_write_q) begin
                        rsp_data_d = 8'h00;
                        rsp_err_d  = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end else if (retry_q >= RETRY_LAST) begin
                    // This refused cycle is the MAX_RETRY-th: give up.
                    retry_d    = RETRY_MAX;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            S_WAIT_DATA: begin
                rsp_data_d = read_data;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM port drive: everything is quiet outside ISSUE.
    always_comb begin
        addr       = 4'h0;
        read       = 1'b0;
        write      = 1'b0;
        write_data = 8'h00;
        if (state_q == S_ISSUE) begin
            addr       = work_addr_q;
            read       = ~work_write_q;
            write      = work_write_q;
            write_data = work_wdata_q;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE) || (count_q != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            state_q      <= S_IDLE;
            work_write_q <= 1'b0;
            work_addr_q  <= 4'h0;
            work_wdata_q <= 8'h00;
            retry_q      <= '0;
            rsp_data_q   <= 8'h00;
            rsp_err_q    <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            work_write_q <= work_write_d;
            work_addr_q  <= work_addr_d;
            work_wdata_q <= work_wdata_d;
            retry_q      <= retry_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Testbench for ram_port_master: directed scenarios plus a randomized run,
// all responses and RAM-port activity checked against an in-order scoreboard.
module tb_ram_port_master;

    localparam int MAX_RETRY = 4;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] addr;
    logic       read;
    logic       write;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       grant;
    logic       busy;

    ram_port_master #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .addr       (addr),
        .read       (read),
        .write      (write),
        .write_data (write_data),
        .read_data  (read_data),
        .grant      (grant),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM port model: access executes on the edge where grant is high.
    logic [7:0] ram [16];
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
        read_data = 8'h00;
        forever begin
            @(posedge clk);
            if (grant && write) ram[addr] <= write_data;
            if (grant && read)  read_data <= ram[addr];
        end
    end

    // Grant driver. gmode: 0 random, 1 always, 2 never, 3 refuse deny_n times.
    int gmode  = 1;
    int deny_n = 0;
    int tries  = 0;
    initial begin
        grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gmode)
                0:       grant = 1'($urandom_range(0, 1));
                1:       grant = 1'b1;
                2:       grant = 1'b0;
                default: grant = (tries >= deny_n);
            endcase
        end
    end

    // Scoreboard: commands accepted but not yet granted/aborted, then
    // responses expected in order.
    typedef struct packed {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
    } cmd_t;
    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t exp_q[$];
    int   n_rsp    = 0;
    int   n_wr_cyc = 0;
    int   n_rd_cyc = 0;

    initial begin
        cmd_t c;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cmd_q.delete();
                exp_q.delete();
                tries = 0;
            end else begin
                check("busy", busy, (cmd_q.size() != 0) || (exp_q.size() != 0));
                if (read)  n_rd_cyc++;
                if (write) n_wr_cyc++;
                if (read || write) begin
                    if (cmd_q.size() == 0) begin
                        check("acc_unexpected", 1, 0);
                    end else begin
                        c = cmd_q[0];
                        check("acc_dir", {read, write}, c.w ? 2'b01 : 2'b10);
                        check("acc_addr", addr, c.a);
                        check("acc_wdata", write_data, c.d);
                        if (grant) begin
                            r.d = c.w ? 8'h00 : ram[c.a];
                            r.e = 1'b0;
                            exp_q.push_back(r);
                            void'(cmd_q.pop_front());
                            tries = 0;
                        end else begin
                            tries++;
                            if (tries == MAX_RETRY) begin
                                r.d = 8'h00;
                                r.e = 1'b1;
                                exp_q.push_back(r);
                                void'(cmd_q.pop_front());
                                tries = 0;
                            end
                        end
                    end
                end else begin
                    check("idle_wdata", write_data, 0);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        check("rsp_data", rsp_data, exp_q[0].d);
                        check("rsp_err", rsp_err, exp_q[0].e);
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            n_rsp++;
                        end
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    c.w = cmd_write;
                    c.a = cmd_addr;
                    c.d = cmd_wdata;
                    cmd_q.push_back(c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_cmd(input logic w, input logic [3:0] a, input logic [7:0] d);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("cmd_accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    // Number of clock edges after the handshake until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 999;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 999) check("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int base;
        int base_rsp;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_addr", addr, 0);
        check("rst_write_data", write_data, 0);
        check("rst_busy", busy, 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        // Write addr 3 = 0xA5, immediate grant.
        gmode = 1;
        base  = n_wr_cyc;
        send_cmd(1'b1, 4'd3, 8'hA5);
        wait_rsp(lat);
        check("wr_latency", lat, 2);
        check("wr_rsp_data", rsp_data, 8'h00);
        check("wr_rsp_err", rsp_err, 0);
        wait_idle();
        check("wr_cycles", n_wr_cyc - base, 1);

        // Read it back.
        send_cmd(1'b0, 4'd3, 8'h5C);
        wait_rsp(lat);
        check("rd_latency", lat, 3);
        check("rd_rsp_data", rsp_data, 8'hA5);
        check("rd_rsp_err", rsp_err, 0);
        wait_idle();

        // Read refused twice, then granted.
        gmode  = 3;
        deny_n = 2;
        base   = n_rd_cyc;
        send_cmd(1'b0, 4'd3, 8'h00);
        wait_rsp(lat);
        check("retry_latency", lat, 5);
        check("retry_rsp_data", rsp_data, 8'hA5);
        check("retry_rsp_err", rsp_err, 0);
        wait_idle();
        check("retry_read_cycles", n_rd_cyc - base, 3);

        // Never granted: abort after MAX_RETRY ISSUE cycles.
        gmode = 2;
        base  = n_rd_cyc;
        send_cmd(1'b0, 4'd7, 8'h3C);
        wait_rsp(lat);
        check("abort_latency", lat, 1 + MAX_RETRY);
        check("abort_rsp_err", rsp_err, 1);
        check("abort_rsp_data", rsp_data, 8'h00);
        wait_idle();
        check("abort_issue_cycles", n_rd_cyc - base, MAX_RETRY);

        // Back-pressure: three commands, response stalled.
        gmode     = 1;
        rsp_ready = 1'b0;
        base_rsp  = n_rsp;
        send_cmd(1'b1, 4'd5, 8'h11);
        send_cmd(1'b0, 4'd5, 8'h00);
        send_cmd(1'b1, 4'd6, 8'h22);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_cmd_ready", cmd_ready, 0);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, 8'h00);
            tick();
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("bp_rsp_count", n_rsp - base_rsp, 3);
        check("bp_ram_5", ram[5], 8'h11);

        // Reset in WAIT_DATA discards the read.
        send_cmd(1'b0, 4'd3, 8'h00);
        tick();
        tick();
        check("pre_rst_read", read, 0);
        check("pre_rst_rsp_valid", rsp_valid, 0);
        check("pre_rst_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        check("mid_rst_read", read, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        tick();
        tick();
        reset    = 1'b1;
        base_rsp = n_rsp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", rsp_valid, 0);
        end
        tick();
        send_cmd(1'b0, 4'd3, 8'h00);
        wait_rsp(lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_rsp_data", rsp_data, 8'hA5);
        wait_idle();
        check("post_rst_rsp_count", n_rsp - base_rsp, 1);

        // Randomized traffic, grant and response back-pressure.
        gmode = 0;
        for (int c = 0; c < 800; c++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 4'($urandom_range(0, 15));
            cmd_wdata = 8'($urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        gmode     = 1;
        wait_idle();
        check("drain_cmd_q", cmd_q.size(), 0);
        check("drain_exp_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_master.md
RAM_PORT_MASTER -- requirements
Module: ram_port_master

Interface
REQ-001 Parameter MAX_RETRY, default 4: number of non-granted ISSUE cycles tolerated before a command is aborted with an error.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command offered; cmd_ready  output  1  command FIFO can accept.
REQ-006 cmd_write  input  1  1 = write, 0 = read; cmd_addr  input  4  word address; cmd_wdata  input  8  write data.
REQ-007 rsp_valid  output  1  response held; rsp_ready  input  1  consumer accepts the response.
REQ-008 rsp_data  output  8  read data, 0 for writes; rsp_err  output  1  command aborted after retry limit.
REQ-009 addr  output  4, read  output  1, write  output  1, write_data  output  8  drive one port of the 16x8 dual-port RAM.
REQ-010 read_data  input  8  RAM port registered read data; grant  input  1  RAM executed this port's access on the current edge.
REQ-011 busy  output  1  FSM not in IDLE or FIFO not empty.

Function
REQ-012 Command FIFO depth 2; push on cmd_valid && cmd_ready; cmd_ready = !full. Readiness SHALL NOT account for a same-cycle pop.
REQ-013 FSM states: IDLE, ISSUE, WAIT_DATA, RESP.
REQ-014 IDLE: FIFO not empty -> pop into work registers (write, addr, wdata), clear retry count, go to ISSUE on the same edge.
REQ-015 ISSUE: addr = work addr; exactly one of read/write = 1; write_data = work wdata. read, write and write_data SHALL be 0 in every other state.
REQ-016 ISSUE with grant = 1 at the edge: a write goes to RESP with rsp_data = 0 and rsp_err = 0; a read goes to WAIT_DATA.
REQ-017 ISSUE with grant = 0 at the edge: the retry count increments and the access is re-driven unchanged.
REQ-018 When the retry count reaches MAX_RETRY with no grant, the FSM goes to RESP with rsp_err = 1 and rsp_data = 0.
REQ-019 WAIT_DATA lasts exactly one cycle: sample read_data into rsp_data, rsp_err = 0, go to RESP.
REQ-020 RESP: rsp_valid = 1. rsp_data and rsp_err SHALL stay stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-021 Latency from the cmd handshake edge to rsp_valid high, with an empty FIFO and immediate grant: write 2 cycles, read 3 cycles.
REQ-022 Responses SHALL be returned in command order, one at a time; no new command is popped while in ISSUE, WAIT_DATA or RESP.
REQ-023 A FIFO push while the FSM is in any state SHALL be accepted if not full. A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-024 The retry counter SHALL be wide enough for MAX_RETRY and SHALL NOT wrap.
REQ-025 grant SHALL be ignored outside ISSUE.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, empty FIFO, retry count 0, cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, read 0, write 0, addr 0, write_data 0, busy 0.
REQ-027 Reset asserted mid-command SHALL discard the in-flight command and all FIFO contents; no response is produced for them.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-029 Write addr 3 data 0xA5 with grant held 1 -> write = 1 for one cycle with addr 3; rsp_valid 2 cycles after the handshake, rsp_data 0x00, rsp_err 0.
REQ-030 Read addr 3 after the write, grant 1, RAM model returns 0xA5 -> rsp_valid 3 cycles after the handshake, rsp_data 0xA5.
REQ-031 Read with grant 0 for 2 cycles, then 1 -> read held 3 cycles with constant addr; rsp_data correct; rsp_err 0.
REQ-032 grant held 0, MAX_RETRY = 4 -> exactly 4 ISSUE cycles, then rsp_valid with rsp_err 1 and rsp_data 0x00.
REQ-033 Three back-to-back commands with rsp_ready = 0 -> cmd_ready falls once the FIFO holds 2; the response holds stable; responses arrive in order after rsp_ready rises.
REQ-034 reset pulsed low during WAIT_DATA -> all outputs zero immediately; no response after release; the next command completes normally.
